spi_input_conditioner: RTL and testbench

//  Front-end stage for the SPI memory block. Synchronizes and debounces raw sclk, cs and mosi

---
 rtl/spi_input_conditioner.sv | 128 ++++++++++++
 tb/tb_spi_input_conditioner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_input_conditioner.sv
// Input conditioner for the SPI memory block: two-flop synchronisers plus a
// debounce counter per pin, with registered edge pulses on accepted changes.

module spi_cond_channel #(
    parameter int   COUNTER_WIDTH = 3,
    parameter int   WAIT_TIME     = 3,
    parameter logic IDLE          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_cond,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [COUNTER_WIDTH-1:0] WAIT_C = COUNTER_WIDTH'(WAIT_TIME);

    logic                     r_sync0;
    logic                     r_sync1;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic                     r_cond;
    logic                     r_rise;
    logic                     r_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0 <= IDLE;
            r_sync1 <= IDLE;
            r_cnt   <= '0;
            r_cond  <= IDLE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync0 <= i_pin;
            r_sync1 <= r_sync0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync1 == r_cond) begin
                r_cnt <= '0;
            end else if (r_cnt == WAIT_C) begin
                // Level held long enough: accept it and flag the direction.
                r_cond <= r_sync1;
                r_cnt  <= '0;
                r_rise <= r_sync1;
                r_fall <= ~r_sync1;
            end else begin
                r_cnt <= r_cnt + COUNTER_WIDTH'(1);
            end
        end
    end

    assign o_cond = r_cond;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

module spi_input_conditioner #(
    parameter int COUNTER_WIDTH = 3,
    parameter int WAIT_TIME     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_in,
    input  logic cs_in,
    input  logic mosi_in,
    output logic sclk_cond,
    output logic sclk_posedge,
    output logic sclk_negedge,
    output logic cs_cond,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_cond
);

    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi_rise;
    logic w_mosi_fall;

    spi_cond_channel #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .WAIT_TIME    (WAIT_TIME),
        .IDLE         (1'b0)
    ) u_sclk (
        .clk   (clk),
        .reset (reset),
        .i_pin (sclk_in),
        .o_cond(sclk_cond),
        .o_rise(sclk_posedge),
        .o_fall(sclk_negedge)
    );

    // Chip select idles high (deasserted).
    spi_cond_channel #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .WAIT_TIME    (WAIT_TIME),
        .IDLE         (1'b1)
    ) u_cs (
        .clk   (clk),
        .reset (reset),
        .i_pin (cs_in),
        .o_cond(cs_cond),
        .o_rise(w_cs_rise),
        .o_fall(w_cs_fall)
    );

    spi_cond_channel #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .WAIT_TIME    (WAIT_TIME),
        .IDLE         (1'b0)
    ) u_mosi (
        .clk   (clk),
        .reset (reset),
        .i_pin (mosi_in),
        .o_cond(mosi_cond),
        .o_rise(w_mosi_rise),
        .o_fall(w_mosi_fall)
    );

    assign cs_rise = w_cs_rise;
    assign cs_fall = w_cs_fall;

    logic w_unused;
    assign w_unused = w_mosi_rise ^ w_mosi_fall;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Bench for spi_input_conditioner: directed table, corner sequences and a
// randomized run checked against a sliding-window reference model.

module tb_spi_input_conditioner;

    localparam int CW   = 3;
    localparam int WT   = 3;
    localparam int HMAX = 8192;
    localparam logic [2:0] IDLE = 3'b010;   // {sclk, cs, mosi}

    logic clk;
    logic reset;
    logic sclk_in, cs_in, mosi_in;
    logic sclk_cond, sclk_posedge, sclk_negedge;
    logic cs_cond, cs_fall, cs_rise, mosi_cond;

    spi_input_conditioner #(
        .COUNTER_WIDTH(CW),
        .WAIT_TIME    (WT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk_in     (sclk_in),
        .cs_in       (cs_in),
        .mosi_in     (mosi_in),
        .sclk_cond   (sclk_cond),
        .sclk_posedge(sclk_posedge),
        .sclk_negedge(sclk_negedge),
        .cs_cond     (cs_cond),
        .cs_fall     (cs_fall),
        .cs_rise     (cs_rise),
        .mosi_cond   (mosi_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Per-edge history of what was presented to the DUT.
    logic [2:0] pin_h [HMAX];
    logic       rst_h [HMAX];
    int         n = 0;

    // Model state: conditioned levels and rise/fall pulses per channel.
    logic [2:0] mc;
    logic [2:0] mr;
    logic [2:0] mf;

    function automatic logic [6:0] got_vec();
        return {sclk_cond, sclk_posedge, sclk_negedge,
                cs_cond, cs_fall, cs_rise, mosi_cond};
    endfunction

    function automatic logic [6:0] model_vec();
        return {mc[2], mr[2], mf[2], mc[1], mf[1], mr[1], mc[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, n, got, exp);
        end
    endtask

    // Level the second synchroniser presents at edge m.
    function automatic logic seen(input int c, input int m);
        if (m < 2) return IDLE[c];
        if (rst_h[m-1] || rst_h[m-2]) return IDLE[c];
        return pin_h[m-2][c];
    endfunction

    // A change is accepted at edge e when the synchronised level has differed
    // from the current level on every non-reset edge of the window e-WT..e.
    task automatic model_edge(input int e);
        bit ok;
        mr = '0;
        mf = '0;
        if (rst_h[e]) begin
            mc = IDLE;
        end else begin
            for (int c = 0; c < 3; c++) begin
                ok = 1'b1;
                for (int j = 0; j <= WT; j++) begin
                    if (e - j < 0) ok = 1'b0;
                    else if (rst_h[e-j]) ok = 1'b0;
                    else if (seen(c, e - j) == mc[c]) ok = 1'b0;
                end
                if (ok) begin
                    mc[c] = ~mc[c];
                    mr[c] = mc[c];
                    mf[c] = ~mc[c];
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic c,
                        input logic m);
        reset   = r;
        sclk_in = s;
        cs_in   = c;
        mosi_in = m;
        pin_h[n] = {s, c, m};
        rst_h[n] = r;
        @(posedge clk);
        model_edge(n);
        @(negedge clk);
        check("model", 32'(got_vec()), 32'(model_vec()));
        n++;
    endtask

    typedef struct {
        logic       rst;
        logic       s;
        logic       c;
        logic       m;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [36];

    logic [2:0] rp;
    int hold [3];
    int first, npos, nfall, nrise, nneg, nbad;
    logic [7:0] data;

    initial begin
        mc = IDLE;
        mr = '0;
        mf = '0;
        reset = 1'b1;
        {sclk_in, cs_in, mosi_in} = IDLE;

        // Directed table: reset, clean sclk edge both ways, cs glitch,
        // then a cs low pulse just long enough to be accepted.
        for (int i = 0; i < 36; i++) begin
            tbl[i].rst = (i < 2);
            tbl[i].s   = 1'b0;
            tbl[i].c   = 1'b1;
            tbl[i].m   = 1'b0;
            tbl[i].exp = 7'b0001000;
        end
        for (int i = 2; i <= 8; i++) tbl[i].s = 1'b1;
        for (int i = 7; i <= 13; i++) tbl[i].exp[6] = 1'b1;
        tbl[7].exp[5]  = 1'b1;
        tbl[14].exp[4] = 1'b1;
        for (int i = 16; i <= 18; i++) tbl[i].c = 1'b0;
        for (int i = 25; i <= 28; i++) tbl[i].c = 1'b0;
        for (int i = 30; i <= 33; i++) tbl[i].exp[3] = 1'b0;
        tbl[30].exp[2] = 1'b1;
        tbl[34].exp[1] = 1'b1;

        for (int i = 0; i < 36; i++) begin
            step(tbl[i].rst, tbl[i].s, tbl[i].c, tbl[i].m);
            check($sformatf("table[%0d]", i), 32'(got_vec()), 32'(tbl[i].exp));
        end

        // Reset with random pins.
        for (int i = 0; i < 2; i++) begin
            rp = 3'($urandom);
            step(1'b1, rp[2], rp[1], rp[0]);
        end
        check("reset_rand", 32'(got_vec()), 32'(7'b0001000));

        // Bounce: mosi 1,0,1 then held.
        first = -1;
        nbad = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, (i == 1) ? 1'b0 : 1'b1);
            if (mosi_cond && first < 0) first = i;
            if (first >= 0 && !mosi_cond) nbad++;
        end
        check("bounce_latency", 32'(first), 32'd7);
        check("bounce_single", 32'(nbad), 32'd0);

        // Frame: cs low, 8 sclk periods carrying 8'hA5 MSB first.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        data  = 8'hA5;
        npos  = 0;
        nneg  = 0;
        nfall = 0;
        nrise = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            nfall += int'(cs_fall);
        end
        for (int b = 0; b < 8; b++) begin
            for (int t = 0; t < 16; t++) begin
                step(1'b0, (t >= 8), 1'b0, data[7-b]);
                nfall += int'(cs_fall);
                nneg  += int'(sclk_negedge);
                if (sclk_posedge) begin
                    if (npos < 8)
                        check($sformatf("frame_bit%0d", npos),
                              32'(mosi_cond), 32'(data[7-npos]));
                    npos++;
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            nrise += int'(cs_rise);
            nfall += int'(cs_fall);
            npos  += int'(sclk_posedge);
            nneg  += int'(sclk_negedge);
        end
        check("frame_posedges", 32'(npos), 32'd8);
        check("frame_negedges", 32'(nneg), 32'd8);
        check("frame_cs_fall", 32'(nfall), 32'd1);
        check("frame_cs_rise", 32'(nrise), 32'd1);
        check("frame_cs_idle", 32'(cs_cond), 32'd1);

        // Reset in the middle of a pending sclk rise.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        first = -1;
        npos  = 0;
        for (int j = 1; j <= 10; j++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (sclk_cond && first < 0) first = j;
            if (sclk_posedge && j < 6) npos++;
        end
        check("rst_mid_latency", 32'(first), 32'd6);
        check("rst_mid_nopulse", 32'(npos), 32'd0);

        // Randomized run with hold times straddling the debounce window.
        rp = IDLE;
        for (int c = 0; c < 3; c++) hold[c] = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    rp[c]   = ~rp[c];
                    hold[c] = int'($urandom_range(1, 7));
                end
            end
            step(($urandom_range(0, 249) == 0), rp[2], rp[1], rp[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
